uart_rx_ext: RTL and testbench
==============================

UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clocks per bit period (legal 4..65535).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame (legal 1 or 2).
REQ-004 SHALL have parameter PARITY_ODD, default 0, parity sense: 0 even, 1 odd (used only under UART_RX_EXT_PARITY_EN).
REQ-005 SHALL have port i_Clock  input  1  sole clock, rising edge.
REQ-006 SHALL have port i_Reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_RX_Serial  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port o_RX_DV  output  1  one-cycle pulse, frame complete.
REQ-009 SHALL have port o_RX_Byte  output  DATA_BITS  received data, LSB first on line.
REQ-010 SHALL have port o_Frame_Err  output  1  a stop bit sampled low, valid with o_RX_DV.
REQ-011 SHALL have port o_Parity_Err  output  1  parity mismatch, valid with o_RX_DV; tied 0 without macro.
REQ-012 SHALL have port o_Break  output  1  high while break condition held.
REQ-013 SHALL have port o_Busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL pass i_RX_Serial through a 2-flop synchroniser; all decisions use the synchronised value.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP, CLEANUP, BREAK_WAIT; undefined encodings go to IDLE.
REQ-016 IDLE: clear counters; go to START when synchronised line is 0.
REQ-017 START: at count (CLKS_PER_BIT-1)/2 sample; 0 -> DATA with count cleared; 1 -> IDLE (glitch rejected, no outputs change).
REQ-018 DATA: sample every CLKS_PER_BIT clocks into bit index 0..DATA_BITS-1; after last bit -> PARITY if macro defined, else STOP.
REQ-019 PARITY: sample after CLKS_PER_BIT clocks; error = XOR(data bits, parity bit) XOR PARITY_ODD != 0.
REQ-020 STOP: sample each stop bit after CLKS_PER_BIT clocks; any 0 sample sets frame error.
REQ-021 The clock after the last stop sample SHALL load o_RX_Byte, o_Frame_Err, o_Parity_Err and pulse o_RX_DV for exactly one cycle, then enter CLEANUP.
REQ-022 o_RX_Byte and error flags SHALL hold until the next o_RX_DV.
REQ-023 CLEANUP: one cycle; -> BREAK_WAIT if frame error and all data, parity and stop samples were 0, else IDLE.
REQ-024 BREAK_WAIT: o_Break=1; stay until synchronised line is 1, then -> IDLE with o_Break=0 next cycle.
REQ-025 Bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide, never wrap past CLKS_PER_BIT-1.
REQ-026 A frame with a frame error SHALL still deliver o_RX_DV and data.

Reset
REQ-027 i_Reset SHALL force IDLE, synchroniser flops to 1, counters 0, all outputs 0, overriding any state incl. mid-frame.
REQ-028 First frame after reset release SHALL be detected normally once line has been high 2 clocks.

Configuration
REQ-029 Macro UART_RX_EXT_PARITY_EN defined: PARITY state and parity check compiled in, frame has one parity bit after data.
REQ-030 Macro undefined: no PARITY state, o_Parity_Err constant 0, frame = start + DATA_BITS + STOP_BITS.

Structure
REQ-031 Package uart_pkg SHALL hold the state enumeration and parameter range constants, shared with the TX side.
REQ-032 Sub-module uart_rx_sync (2-flop synchroniser, reset value 1) SHALL be instantiated once.

Verification (CLKS_PER_BIT=16 in all)
REQ-033 Frame 0xA5, 8N1, clean -> one o_RX_DV pulse, o_RX_Byte=0xA5, both error flags 0.
REQ-034 Start low for 5 clocks then high -> no o_RX_DV, returns IDLE, o_Busy low by clock 12.
REQ-035 0x3C with stop bit driven 0 -> o_RX_DV, o_RX_Byte=0x3C, o_Frame_Err=1; next clean 0x55 clears flag.
REQ-036 Line held 0 for 20 bit periods -> o_RX_DV with 0x00, o_Frame_Err=1, o_Break=1 until line returns 1.
REQ-037 Macro defined, PARITY_ODD=0, 0x07 with parity bit 0 -> o_Parity_Err=1; parity bit 1 -> o_Parity_Err=0.
REQ-038 i_Reset pulsed at data bit 4 of a frame -> outputs 0, no o_RX_DV, next full frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and parameter range limits for the RX and TX sides
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        CLEANUP    = 3'd5,
        BREAK_WAIT = 3'd6
    } uart_state_t;

    localparam int CLKS_PER_BIT_MIN = 4;
    localparam int CLKS_PER_BIT_MAX = 65535;
    localparam int DATA_BITS_MIN    = 5;
    localparam int DATA_BITS_MAX    = 9;
    localparam int STOP_BITS_MIN    = 1;
    localparam int STOP_BITS_MAX    = 2;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the idle-high serial line
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Reset to the idle level so a reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) {q, meta} <= 2'b11;
        else     {q, meta} <= {meta, d};
    end

endmodule

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: UART receiver with frame-error and break detection; parity check enabled by UART_RX_EXT_PARITY_EN
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Frame_Err,
    output logic                 o_Parity_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

    uart_state_t          state, state_next;
    logic                 rx;
    logic [CW-1:0]        count;
    logic [IW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 frame_acc;
    logic                 all_zero;
    logic                 tick, mid, last_bit, stop_last;

    uart_rx_sync u_sync (
        .clk(i_Clock),
        .rst(i_Reset),
        .d  (i_RX_Serial),
        .q  (rx)
    );

    assign tick      = count == LAST;
    assign mid       = count == HALF;
    assign last_bit  = bit_idx == IW'(DATA_BITS - 1);
    assign stop_last = (STOP_BITS == 1) || stop_idx;
    assign o_Busy    = state != IDLE;
    assign o_Break   = state == BREAK_WAIT;

    // State register
    always_ff @(posedge i_Clock) begin
        if (i_Reset) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic; a frame of all-zero samples with a bad stop bit is a break
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       state_next = rx ? IDLE : START;
            START:      if (mid) state_next = rx ? IDLE : DATA;
`ifdef UART_RX_EXT_PARITY_EN
            DATA:       if (tick && last_bit) state_next = PARITY;
            PARITY:     if (tick) state_next = STOP;
`else
            DATA:       if (tick && last_bit) state_next = STOP;
`endif
            STOP:       if (tick && stop_last) state_next = CLEANUP;
            CLEANUP:    state_next = (o_Frame_Err && all_zero) ? BREAK_WAIT : IDLE;
            BREAK_WAIT: if (rx) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

`ifdef UART_RX_EXT_PARITY_EN
    logic par_err;
`else
    assign o_Parity_Err = 1'b0;
`endif

    // Bit timing, sampling, and result registers; results load on the last stop sample
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            count       <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            shift       <= '0;
            frame_acc   <= 1'b0;
            all_zero    <= 1'b1;
            o_RX_DV     <= 1'b0;
            o_RX_Byte   <= '0;
            o_Frame_Err <= 1'b0;
`ifdef UART_RX_EXT_PARITY_EN
            par_err      <= 1'b0;
            o_Parity_Err <= 1'b0;
`endif
        end else begin
            o_RX_DV <= 1'b0;
            case (state)
                START: count <= mid ? '0 : count + CW'(1);
                DATA: begin
                    count <= tick ? '0 : count + CW'(1);
                    if (tick) begin
                        shift    <= {rx, shift[DATA_BITS-1:1]};
                        bit_idx  <= bit_idx + IW'(1);
                        all_zero <= all_zero & ~rx;
                    end
                end
`ifdef UART_RX_EXT_PARITY_EN
                PARITY: begin
                    count <= tick ? '0 : count + CW'(1);
                    if (tick) begin
                        par_err  <= ^shift ^ rx ^ (PARITY_ODD != 0);
                        all_zero <= all_zero & ~rx;
                    end
                end
`endif
                STOP: begin
                    count <= tick ? '0 : count + CW'(1);
                    if (tick) begin
                        stop_idx  <= ~stop_idx;
                        frame_acc <= frame_acc | ~rx;
                        all_zero  <= all_zero & ~rx;
                        if (stop_last) begin
                            o_RX_DV     <= 1'b1;
                            o_RX_Byte   <= shift;
                            o_Frame_Err <= frame_acc | ~rx;
`ifdef UART_RX_EXT_PARITY_EN
                            o_Parity_Err <= par_err;
`endif
                        end
                    end
                end
                CLEANUP: count <= '0;
                default: begin
                    count     <= '0;
                    bit_idx   <= '0;
                    stop_idx  <= 1'b0;
                    frame_acc <= 1'b0;
                    all_zero  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext: directed checks of uart_rx_ext at 16 clocks per bit, 8N1
module tb_uart_rx_ext;

    localparam int CPB = 16;

    logic       i_Clock = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_RX_Serial = 1'b1;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       o_Frame_Err;
    logic       o_Parity_Err;
    logic       o_Break;
    logic       o_Busy;

    int         na = 0;
    int         nf = 0;
    int         dv_cnt = 0;
    int         dv_wide = 0;
    logic       dv_prev = 1'b0;
    logic [7:0] cap_byte = 8'h00;
    logic       cap_fe = 1'b0;
    logic       cap_pe = 1'b0;

    always #5 i_Clock = ~i_Clock;

    uart_rx_ext #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_RX_Serial (i_RX_Serial),
        .o_RX_DV     (o_RX_DV),
        .o_RX_Byte   (o_RX_Byte),
        .o_Frame_Err (o_Frame_Err),
        .o_Parity_Err(o_Parity_Err),
        .o_Break     (o_Break),
        .o_Busy      (o_Busy)
    );

    // Capture each data-valid pulse and note any pulse lasting more than one cycle
    always @(negedge i_Clock) begin
        if (o_RX_DV) begin
            dv_cnt++;
            cap_byte = o_RX_Byte;
            cap_fe = o_Frame_Err;
            cap_pe = o_Parity_Err;
            if (dv_prev) dv_wide++;
        end
        dv_prev = o_RX_DV;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_Clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        i_RX_Serial = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_EXT_PARITY_EN
        send_bit(par);
`endif
        send_bit(stop);
        i_RX_Serial = 1'b1;
        tick(24);
    endtask

    task automatic test_reset;
        i_Reset = 1'b1;
        i_RX_Serial = 1'b1;
        tick(4);
        na++; if (o_RX_DV !== 1'b0) begin nf++; $display("FAIL reset_dv: got %b expected 0", o_RX_DV); end
        na++; if (o_RX_Byte !== 8'h00) begin nf++; $display("FAIL reset_byte: got %h expected 00", o_RX_Byte); end
        na++; if (o_Frame_Err !== 1'b0) begin nf++; $display("FAIL reset_fe: got %b expected 0", o_Frame_Err); end
        na++; if (o_Parity_Err !== 1'b0) begin nf++; $display("FAIL reset_pe: got %b expected 0", o_Parity_Err); end
        na++; if (o_Break !== 1'b0) begin nf++; $display("FAIL reset_break: got %b expected 0", o_Break); end
        na++; if (o_Busy !== 1'b0) begin nf++; $display("FAIL reset_busy: got %b expected 0", o_Busy); end
        i_Reset = 1'b0;
        tick(2);
    endtask

    task automatic test_clean;
        int b;
        b = dv_cnt;
        send_frame(8'hA5, ^8'hA5, 1'b1);
        na++; if (dv_cnt - b !== 1) begin nf++; $display("FAIL clean_dv: got %0d pulses expected 1", dv_cnt - b); end
        na++; if (cap_byte !== 8'hA5) begin nf++; $display("FAIL clean_byte: got %h expected a5", cap_byte); end
        na++; if (cap_fe !== 1'b0) begin nf++; $display("FAIL clean_fe: got %b expected 0", cap_fe); end
        na++; if (cap_pe !== 1'b0) begin nf++; $display("FAIL clean_pe: got %b expected 0", cap_pe); end
        na++; if (dv_wide !== 0) begin nf++; $display("FAIL clean_dv_width: got %0d long pulses expected 0", dv_wide); end
        na++; if (o_Busy !== 1'b0) begin nf++; $display("FAIL clean_busy: got %b expected 0", o_Busy); end
    endtask

    task automatic test_glitch;
        int b;
        b = dv_cnt;
        i_RX_Serial = 1'b0;
        tick(5);
        na++; if (o_Busy !== 1'b1) begin nf++; $display("FAIL glitch_busy_start: got %b expected 1", o_Busy); end
        i_RX_Serial = 1'b1;
        tick(7);
        na++; if (o_Busy !== 1'b0) begin nf++; $display("FAIL glitch_busy_end: got %b expected 0", o_Busy); end
        na++; if (dv_cnt !== b) begin nf++; $display("FAIL glitch_dv: got %0d pulses expected 0", dv_cnt - b); end
        na++; if (o_RX_Byte !== 8'hA5) begin nf++; $display("FAIL glitch_hold: got %h expected a5", o_RX_Byte); end
        tick(20);
    endtask

    task automatic test_frame_err;
        int b;
        b = dv_cnt;
        send_frame(8'h3C, ^8'h3C, 1'b0);
        na++; if (dv_cnt - b !== 1) begin nf++; $display("FAIL ferr_dv: got %0d pulses expected 1", dv_cnt - b); end
        na++; if (cap_byte !== 8'h3C) begin nf++; $display("FAIL ferr_byte: got %h expected 3c", cap_byte); end
        na++; if (cap_fe !== 1'b1) begin nf++; $display("FAIL ferr_flag: got %b expected 1", cap_fe); end
        na++; if (o_Frame_Err !== 1'b1) begin nf++; $display("FAIL ferr_hold: got %b expected 1", o_Frame_Err); end
        na++; if (o_Break !== 1'b0) begin nf++; $display("FAIL ferr_break: got %b expected 0", o_Break); end
        send_frame(8'h55, ^8'h55, 1'b1);
        na++; if (cap_byte !== 8'h55) begin nf++; $display("FAIL ferr_next_byte: got %h expected 55", cap_byte); end
        na++; if (cap_fe !== 1'b0) begin nf++; $display("FAIL ferr_clear: got %b expected 0", cap_fe); end
    endtask

    task automatic test_break;
        int b;
        b = dv_cnt;
        i_RX_Serial = 1'b0;
        tick(20 * CPB);
        na++; if (dv_cnt - b !== 1) begin nf++; $display("FAIL break_dv: got %0d pulses expected 1", dv_cnt - b); end
        na++; if (cap_byte !== 8'h00) begin nf++; $display("FAIL break_byte: got %h expected 00", cap_byte); end
        na++; if (cap_fe !== 1'b1) begin nf++; $display("FAIL break_fe: got %b expected 1", cap_fe); end
        na++; if (o_Break !== 1'b1) begin nf++; $display("FAIL break_flag: got %b expected 1", o_Break); end
        na++; if (o_Busy !== 1'b1) begin nf++; $display("FAIL break_busy: got %b expected 1", o_Busy); end
        i_RX_Serial = 1'b1;
        tick(1);
        na++; if (o_Break !== 1'b1) begin nf++; $display("FAIL break_held: got %b expected 1", o_Break); end
        tick(3);
        na++; if (o_Break !== 1'b0) begin nf++; $display("FAIL break_release: got %b expected 0", o_Break); end
        na++; if (o_Busy !== 1'b0) begin nf++; $display("FAIL break_idle: got %b expected 0", o_Busy); end
        tick(20);
    endtask

    task automatic test_parity;
`ifdef UART_RX_EXT_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b1);
        na++; if (cap_byte !== 8'h07) begin nf++; $display("FAIL par_byte: got %h expected 07", cap_byte); end
        na++; if (cap_pe !== 1'b1) begin nf++; $display("FAIL par_bad: got %b expected 1", cap_pe); end
        send_frame(8'h07, 1'b1, 1'b1);
        na++; if (cap_pe !== 1'b0) begin nf++; $display("FAIL par_good: got %b expected 0", cap_pe); end
`else
        send_frame(8'h07, 1'b0, 1'b1);
        na++; if (cap_byte !== 8'h07) begin nf++; $display("FAIL par_byte: got %h expected 07", cap_byte); end
        na++; if (cap_pe !== 1'b0) begin nf++; $display("FAIL par_tied: got %b expected 0", cap_pe); end
`endif
    endtask

    task automatic test_reset_mid;
        int b;
        logic [7:0] d;
        d = 8'h5A;
        b = dv_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        i_RX_Serial = d[4];
        tick(8);
        i_Reset = 1'b1;
        tick(2);
        na++; if (o_Busy !== 1'b0) begin nf++; $display("FAIL rmid_busy: got %b expected 0", o_Busy); end
        na++; if (o_RX_Byte !== 8'h00) begin nf++; $display("FAIL rmid_byte: got %h expected 00", o_RX_Byte); end
        na++; if (o_RX_DV !== 1'b0) begin nf++; $display("FAIL rmid_dv: got %b expected 0", o_RX_DV); end
        na++; if (o_Frame_Err !== 1'b0) begin nf++; $display("FAIL rmid_fe: got %b expected 0", o_Frame_Err); end
        na++; if (o_Parity_Err !== 1'b0) begin nf++; $display("FAIL rmid_pe: got %b expected 0", o_Parity_Err); end
        i_Reset = 1'b0;
        i_RX_Serial = 1'b1;
        tick(3 * CPB);
        na++; if (dv_cnt !== b) begin nf++; $display("FAIL rmid_no_dv: got %0d pulses expected 0", dv_cnt - b); end
        send_frame(8'h81, ^8'h81, 1'b1);
        na++; if (dv_cnt - b !== 1) begin nf++; $display("FAIL rmid_next_dv: got %0d pulses expected 1", dv_cnt - b); end
        na++; if (cap_byte !== 8'h81) begin nf++; $display("FAIL rmid_next_byte: got %h expected 81", cap_byte); end
        na++; if (cap_fe !== 1'b0) begin nf++; $display("FAIL rmid_next_fe: got %b expected 0", cap_fe); end
    endtask

    initial begin
        test_reset;
        test_clean;
        test_glitch;
        test_frame_err;
        test_break;
        test_parity;
        test_reset_mid;
        na++; if (dv_wide !== 0) begin nf++; $display("FAIL dv_width_total: got %0d long pulses expected 0", dv_wide); end
        $display("End of test - %0d assertions evaluated, %0d failures", na, nf);
        $finish;
    end

endmodule
